// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width; never below one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/carry_lookahead_4b.sv
// 4-bit combinational carry-lookahead adder slice (generate/propagate form).
module carry_lookahead_4b
    import cla_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat function of g, p and cin; no ripple between bits.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[NIBBLE_W-1:0];
    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// WIDTH-bit adder built by sequencing one 4-bit CLA slice over the operand
// nibbles, LSB first, with valid/ready handshakes on both sides.
module cla_multiword_add_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_r, a_d;
    logic [WIDTH-1:0]   b_r, b_d;
    logic               carry_r, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_d, ovf_d;
    logic               in_ready_d, out_valid_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, cla_sum;
    logic                cla_cout;

    // Select the current nibble of each operand.
    assign nib_a = NIBBLE_W'(a_r >> (32'(idx_q) * NIBBLE_W));
    assign nib_b = NIBBLE_W'(b_r >> (32'(idx_q) * NIBBLE_W));

    carry_lookahead_4b u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_r),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx_q     <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_r       <= a_d;
            b_r       <= b_d;
            carry_r   <= carry_d;
            idx_q     <= idx_d;
            sum       <= sum_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Handshake flags are computed from the next state so they stay pure flops.
    always_comb begin
        state_d     = state_q;
        a_d         = a_r;
        b_d         = b_r;
        carry_d     = carry_r;
        idx_d       = idx_q;
        sum_d       = sum;
        cout_d      = cout;
        ovf_d       = ovf;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    idx_d      = '0;
                    sum_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = cla_sum;
                    end
                end
                carry_d = cla_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d      = cla_cout;
                    ovf_d       = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                  (cla_sum[NIBBLE_W-1] != a_r[WIDTH-1]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Directed scoreboard bench for cla_multiword_add_ctrl at WIDTH=16.
module tb_cla_multiword_add_ctrl;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    cla_multiword_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        exp_t       e;
        logic [W:0] t;
        t      = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_in_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    // Drive one operand set; returns 1 ns after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        wait_in_ready();
        a        = x;
        b        = y;
        cin      = c;
        in_valid = 1'b1;
        sb.push_back(model(x, y, c));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input string tag);
        exp_t e;
        wait_out_valid();
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"},  32'(sum),  32'(e.sum));
            check({tag, "_cout"}, 32'(cout), 32'(e.cout));
            check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_ir_back"}, 32'(in_ready),  32'd1);
            check({tag, "_sum_kept"}, 32'(sum), 32'(e.sum));
        end
    endtask

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset values
        #12;
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add with latency check: out_valid first high 4 edges after accept
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        sb.push_back(model(16'h1234, 16'h1111, 1'b0));
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("lat_ov_%0d", k), 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("lat_ir_%0d", k), 32'(in_ready), 32'd0);
            if (k < 4) @(posedge clk);
        end
        check("basic_sum_const", 32'(sum), 32'h2345);
        recv("basic");

        // Carry ripples across every nibble
        send(16'hFFFF, 16'h0001, 1'b0);
        recv("ripple");

        // Signed overflow cases
        send(16'h7FFF, 16'h0000, 1'b1);
        recv("ovf_pos");
        send(16'h8000, 16'h8000, 1'b0);
        recv("ovf_neg");

        // Backpressure and in_valid ignored during RUN
        send(16'h1357, 16'h2468, 1'b0);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h0000; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out_valid();
        e = sb[0];
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_ov_%0d", k),  32'(out_valid), 32'd1);
            check($sformatf("bp_ir_%0d", k),  32'(in_ready),  32'd0);
            check($sformatf("bp_sum_%0d", k), 32'(sum),       32'(e.sum));
            @(negedge clk);
        end
        recv("bp");
        @(negedge clk);
        check("bp_no_ghost", 32'(out_valid), 32'd0);

        // Reset during RUN at idx=2 discards the op
        send(16'h5555, 16'h1111, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov",  32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum),       32'd0);
        check("mid_rst_ir",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        repeat (6) @(negedge clk);
        check("mid_rst_no_out", 32'(out_valid), 32'd0);
        send(16'h0F0F, 16'h00F1, 1'b1);
        recv("post_rst");

        // Random operands
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            recv($sformatf("rand_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
